// File: rtl/input_window_sequencer.sv
// -----------------------------------------------------------------------------
// input_window_sequencer
//
// CNN-mode feeder that sits directly in front of the input shift buffer.
// For each row it does the following:
//   - fetches one activation word from memory;
//   - issues a parallel window load into the buffer;
//   - repeats fetch + strided serial shift until the row is consumed.
// Progress is throttled by memory latency and by array_ready from the PE array.
//
// Optional feature (macro SEQ_STALL_CNT_EN):
//   - adds output stall_cnt[15:0], a saturating count of stall cycles;
//   - a stall cycle is a memory wait (mem_req && !mem_valid) or a SHIFT cycle
//     with array_ready low;
//   - the counter is zeroed on start, clear and reset.
//
// Ports:
//   clk, reset          clock, asynchronous active-low reset
//   clear               synchronous abort back to IDLE
//   start               one-cycle pulse in IDLE; latches cfg_row_len / cfg_stride
//   cfg_row_len         pixels in the row (must be >= N_DIM_ARRAY)
//   cfg_stride          pixels per shift (1..N_DIM_ARRAY)
//   array_ready         PE array can take a new window this cycle
//   mem_req / mem_valid / mem_rdata   word fetch handshake (lane i = pixel i)
//   buf_load            parallel load strobe to the buffer
//   buf_enable          serial shift strobe to the buffer
//   buf_shift           shift amount for this strobe
//   buf_parallel_data   window data for the parallel load
//   buf_serial_data     shift data; lanes >= buf_shift are driven 0
//   busy                high in any state other than IDLE and DONE
//   done                one-cycle pulse at the end of a row or on a rejected start
//   cfg_err             sticky; set by a rejected start, cleared by an accepted one
// -----------------------------------------------------------------------------
module input_window_sequencer #(
   parameter int N_DIM_ARRAY = 4,
   parameter int DATA_WIDTH  = 8,
   parameter int COL_W       = 10
) (
   input  logic                              clk,
   input  logic                              reset,
   input  logic                              clear,
   input  logic                              start,
   input  logic [COL_W-1:0]                  cfg_row_len,
   input  logic [7:0]                        cfg_stride,
   input  logic                              array_ready,
   output logic                              mem_req,
   input  logic                              mem_valid,
   input  logic [N_DIM_ARRAY*DATA_WIDTH-1:0] mem_rdata,
   output logic                              buf_load,
   output logic                              buf_enable,
   output logic [7:0]                        buf_shift,
   output logic [N_DIM_ARRAY*DATA_WIDTH-1:0] buf_parallel_data,
   output logic [N_DIM_ARRAY*DATA_WIDTH-1:0] buf_serial_data,
   output logic                              busy,
   output logic                              done,
   output logic                              cfg_err
`ifdef SEQ_STALL_CNT_EN
   ,
   output logic [15:0]                       stall_cnt
`endif
);

   localparam int                W     = N_DIM_ARRAY * DATA_WIDTH;
   localparam logic [COL_W-1:0]  N_COL = COL_W'(N_DIM_ARRAY);

   typedef enum logic [2:0] {
      IDLE,
      FETCH_P,
      LOAD,
      LOAD_HOLD,
      FETCH_S,
      SHIFT,
      DONE
   } state_t;

   state_t           state_q, state_d;
   logic [COL_W-1:0] col_q, col_d;
   logic [COL_W-1:0] row_len_q;
   logic [7:0]       stride_q;
   logic [W-1:0]     data_q;
   logic             done_q;
   logic             cfg_err_q;

   logic             cfg_bad;
   logic             accept;
   logic             reject;
   logic [COL_W-1:0] rem;
   logic [7:0]       shift_amt;
   logic [COL_W:0]   col_sum;
   logic             row_end;

   assign cfg_bad = (cfg_row_len < N_COL) || (cfg_stride == 8'd0) ||
                    (cfg_stride > 8'(N_DIM_ARRAY));

   // col never exceeds row_len, so the remaining count cannot underflow.
   assign rem = row_len_q - col_q;

   // Partial final shift when fewer than stride pixels are left in the row.
   assign shift_amt = ({1'b0, rem} < (COL_W+1)'(stride_q)) ? 8'(rem) : stride_q;

   // One extra bit so the end-of-row compare cannot be fooled by a wrap.
   assign col_sum = {1'b0, col_q} + (COL_W+1)'(shift_amt);
   assign row_end = (col_sum == {1'b0, row_len_q});

   // NOTE: every signal driven here gets a default first, so no path through
   // the case statement can leave a value unassigned and infer a latch.
   always_comb begin
      state_d           = state_q;
      col_d             = col_q;
      accept            = 1'b0;
      reject            = 1'b0;
      mem_req           = 1'b0;
      buf_load          = 1'b0;
      buf_enable        = 1'b0;
      buf_shift         = 8'd0;
      buf_parallel_data = '0;
      buf_serial_data   = '0;

      unique case (state_q)
         IDLE: begin
            if (start) begin
               if (cfg_bad) begin
                  reject = 1'b1;
               end else begin
                  accept  = 1'b1;
                  col_d   = '0;
                  state_d = FETCH_P;
               end
            end
         end
         FETCH_P: begin
            mem_req = 1'b1;
            if (mem_valid) state_d = LOAD;
         end
         LOAD: begin
            buf_load          = 1'b1;
            buf_parallel_data = data_q;
            col_d             = N_COL;
            state_d           = LOAD_HOLD;
         end
         LOAD_HOLD: begin
            // The buffer registers the load, so the data stays up for a second cycle.
            buf_parallel_data = data_q;
            state_d           = (col_q == row_len_q) ? DONE : FETCH_S;
         end
         FETCH_S: begin
            mem_req = 1'b1;
            if (mem_valid) state_d = SHIFT;
         end
         SHIFT: begin
            if (array_ready) begin
               buf_enable = 1'b1;
               buf_shift  = shift_amt;
               for (int i = 0; i < N_DIM_ARRAY; i++) begin
                  if (i < int'(shift_amt)) begin
                     buf_serial_data[i*DATA_WIDTH +: DATA_WIDTH] =
                        data_q[i*DATA_WIDTH +: DATA_WIDTH];
                  end
               end
               col_d   = col_sum[COL_W-1:0];
               state_d = row_end ? DONE : FETCH_S;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      // Abort wins over every transition, including a start in the same cycle.
      if (clear) begin
         state_d = IDLE;
         col_d   = '0;
         accept  = 1'b0;
         reject  = 1'b0;
      end
   end

   // NOTE: state registers use non-blocking assignments so every flop samples
   // the pre-edge value of its neighbours, independent of block ordering.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= IDLE;
         col_q     <= '0;
         row_len_q <= '0;
         stride_q  <= 8'd0;
         data_q    <= '0;
         done_q    <= 1'b0;
         cfg_err_q <= 1'b0;
      end else begin
         state_q <= state_d;
         col_q   <= col_d;
         done_q  <= reject || (state_d == DONE);

         if (accept) begin
            row_len_q <= cfg_row_len;
            stride_q  <= cfg_stride;
         end

         // A response arriving in the clear cycle is dropped.
         if (mem_req && mem_valid && !clear) begin
            data_q <= mem_rdata;
         end

         if (clear || accept) begin
            cfg_err_q <= 1'b0;
         end else if (reject) begin
            cfg_err_q <= 1'b1;
         end
      end
   end

   assign busy    = (state_q != IDLE) && (state_q != DONE);
   assign done    = done_q;
   assign cfg_err = cfg_err_q;

`ifdef SEQ_STALL_CNT_EN
   logic [15:0] stall_cnt_q;
   logic        stall_evt;

   assign stall_evt = (mem_req && !mem_valid) || ((state_q == SHIFT) && !array_ready);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         stall_cnt_q <= 16'd0;
      end else if (clear || ((state_q == IDLE) && start)) begin
         stall_cnt_q <= 16'd0;
      end else if (stall_evt && (stall_cnt_q != 16'hFFFF)) begin
         stall_cnt_q <= stall_cnt_q + 16'd1;
      end
   end

   assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_input_window_sequencer.sv
// -----------------------------------------------------------------------------
// tb_input_window_sequencer
//
// Directed bench for input_window_sequencer (N=4, DATA_WIDTH=8, COL_W=10).
// A small memory responder answers each request after a programmable number of
// wait cycles; word k carries pixel values 16*k + lane + 1. Outputs are sampled
// on the falling edge; inputs change 2 time units after the rising edge.
// -----------------------------------------------------------------------------
module tb_input_window_sequencer;

   localparam int N     = 4;
   localparam int DW    = 8;
   localparam int COL_W = 10;
   localparam int W     = N * DW;

   logic             clk = 1'b0;
   logic             reset;
   logic             clear;
   logic             start;
   logic [COL_W-1:0] cfg_row_len;
   logic [7:0]       cfg_stride;
   logic             array_ready;
   logic             mem_req;
   logic             mem_valid;
   logic [W-1:0]     mem_rdata;
   logic             buf_load;
   logic             buf_enable;
   logic [7:0]       buf_shift;
   logic [W-1:0]     buf_parallel_data;
   logic [W-1:0]     buf_serial_data;
   logic             busy;
   logic             done;
   logic             cfg_err;
`ifdef SEQ_STALL_CNT_EN
   logic [15:0]      stall_cnt;
`endif

   int n_checks = 0;
   int n_errors = 0;

   // Memory responder / ready-stall model state.
   int k, cnt, lat_g, stall_g, low_left;
   bit stalled_once;

   input_window_sequencer #(
      .N_DIM_ARRAY(N),
      .DATA_WIDTH (DW),
      .COL_W      (COL_W)
   ) dut (
      .clk              (clk),
      .reset            (reset),
      .clear            (clear),
      .start            (start),
      .cfg_row_len      (cfg_row_len),
      .cfg_stride       (cfg_stride),
      .array_ready      (array_ready),
      .mem_req          (mem_req),
      .mem_valid        (mem_valid),
      .mem_rdata        (mem_rdata),
      .buf_load         (buf_load),
      .buf_enable       (buf_enable),
      .buf_shift        (buf_shift),
      .buf_parallel_data(buf_parallel_data),
      .buf_serial_data  (buf_serial_data),
      .busy             (busy),
      .done             (done),
      .cfg_err          (cfg_err)
`ifdef SEQ_STALL_CNT_EN
      ,
      .stall_cnt        (stall_cnt)
`endif
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic [W-1:0] word(input int idx);
      logic [W-1:0] w;
      for (int i = 0; i < N; i++) w[i*DW +: DW] = 8'(16 * idx + i + 1);
      return w;
   endfunction

   function automatic logic [W-1:0] masked(input logic [W-1:0] w, input int s);
      logic [W-1:0] m = '0;
      for (int i = 0; i < N; i++) if (i < s) m[i*DW +: DW] = w[i*DW +: DW];
      return m;
   endfunction

   function automatic logic any_out();
      logic a;
      a = |{mem_req, buf_load, buf_enable, buf_shift, buf_parallel_data,
            buf_serial_data, busy, done, cfg_err};
`ifdef SEQ_STALL_CNT_EN
      a = a | (|stall_cnt);
`endif
      return a;
   endfunction

   task automatic model_reset(input int lat, input int stall);
      k = 0; cnt = 0; lat_g = lat; stall_g = stall; low_left = 0;
      stalled_once = 1'b0;
      mem_valid = 1'b0; mem_rdata = '0; array_ready = 1'b1;
   endtask

   // One clock: rising edge, update responder and ready, return at falling edge.
   task automatic tick();
      @(posedge clk);
      #2;
      if (!array_ready) begin
         if (low_left == 0) array_ready = 1'b1;
         else low_left--;
      end
      if (mem_valid) begin
         // mem_req was high for the whole cycle, so a transfer just happened.
         k++; cnt = 0; mem_valid = 1'b0; mem_rdata = '0;
         if (k == 2 && stall_g > 0 && !stalled_once) begin
            stalled_once = 1'b1;
            array_ready  = 1'b0;
            low_left     = stall_g - 1;
         end
      end else if (mem_req) begin
         if (cnt == lat_g) begin
            mem_valid = 1'b1;
            mem_rdata = word(k);
         end else begin
            cnt++;
         end
      end
      @(negedge clk);
   endtask

   task automatic run_row(input string tag, input int rl, input int st, input int lat,
                          input int stall, input int exp_shifts);
      int loads = 0, nsh = 0, dones = 0, reqs = 0, bad_idle = 0;
      int load_t = -1, done_t = -1, t_end = 1000, col = N, s;
      bit hold_pend = 1'b0, fin = 1'b0;
      model_reset(lat, stall);
      cfg_row_len = 10'(rl);
      cfg_stride  = 8'(st);
      start       = 1'b1;
      for (int t = 0; t < 300; t++) begin
         tick();
         if (t == 0) start = 1'b0;
         if (mem_req) reqs++;
         if (hold_pend) begin
            check({tag, " hold_data"}, 64'(buf_parallel_data), 64'(word(0)));
            check({tag, " hold_load"}, 64'(buf_load), 64'd0);
            check({tag, " hold_en"}, 64'(buf_enable), 64'd0);
            hold_pend = 1'b0;
         end
         if (buf_load) begin
            loads++;
            load_t = t;
            check({tag, " pdata"}, 64'(buf_parallel_data), 64'(word(0)));
            hold_pend = 1'b1;
         end
         if (!array_ready) check({tag, " en_stall"}, 64'(buf_enable), 64'd0);
         if (buf_enable) begin
            s = (rl - col < st) ? rl - col : st;
            check({tag, " shift"}, 64'(buf_shift), 64'(s));
            check({tag, " sdata"}, 64'(buf_serial_data), 64'(masked(word(nsh + 1), s)));
            col += s;
            nsh++;
         end else if (buf_shift != 8'd0 || buf_serial_data != '0) begin
            bad_idle++;
         end
         if (done) begin
            dones++;
            if (dones == 1) begin
               done_t = t;
               t_end  = t + 3;
            end
         end
         if (t == t_end) begin
            fin = 1'b1;
            break;
         end
      end
      check({tag, " finished"}, 64'(fin), 64'd1);
      check({tag, " loads"}, 64'(loads), 64'd1);
      check({tag, " shifts"}, 64'(nsh), 64'(exp_shifts));
      check({tag, " dones"}, 64'(dones), 64'd1);
      check({tag, " col_end"}, 64'(col), 64'(rl));
      // Cycles from the start cycle to buf_load: tick t is cycle t+1.
      check({tag, " load_lat"}, 64'(load_t + 1), 64'(2 + lat));
      if (exp_shifts == 0) check({tag, " done_gap"}, 64'(done_t - load_t), 64'd2);
      check({tag, " req_cycles"}, 64'(reqs), 64'((lat + 1) * (1 + exp_shifts)));
      check({tag, " idle_shift_zero"}, 64'(bad_idle), 64'd0);
      check({tag, " cfg_err"}, 64'(cfg_err), 64'd0);
      check({tag, " busy_end"}, 64'(busy), 64'd0);
`ifdef SEQ_STALL_CNT_EN
      check({tag, " stall_cnt"}, 64'(stall_cnt), 64'(lat * (1 + exp_shifts) + stall));
`endif
   endtask

   task automatic run_reject(input string tag, input int rl, input int st);
      int reqs = 0, dones = 0;
      model_reset(0, 0);
      cfg_row_len = 10'(rl);
      cfg_stride  = 8'(st);
      start       = 1'b1;
      for (int t = 0; t < 6; t++) begin
         tick();
         if (t == 0) begin
            start = 1'b0;
            check({tag, " done_now"}, 64'(done), 64'd1);
         end
         if (mem_req) reqs++;
         if (done) dones++;
      end
      check({tag, " no_req"}, 64'(reqs), 64'd0);
      check({tag, " dones"}, 64'(dones), 64'd1);
      check({tag, " cfg_err"}, 64'(cfg_err), 64'd1);
      check({tag, " busy"}, 64'(busy), 64'd0);
   endtask

   initial begin
      reset = 1'b0; clear = 1'b0; start = 1'b0;
      cfg_row_len = '0; cfg_stride = '0;
      model_reset(0, 0);
      repeat (3) @(negedge clk);
      check("reset_outputs", 64'(any_out()), 64'd0);
      reset = 1'b1;
      @(negedge clk);

      run_row("T1", 10, 2, 0, 0, 3);
      run_row("T2", 9, 2, 0, 0, 3);
      run_row("T3", 4, 1, 0, 0, 0);
      run_row("T4", 10, 2, 3, 5, 3);
      run_row("stride4", 12, 4, 1, 0, 2);

      run_reject("T5_stride0", 10, 0);
      run_reject("T5_row3", 3, 2);
      run_reject("T5_stride5", 10, 5);
      run_row("T5_recover", 10, 2, 0, 0, 3);

      // T6a: park in SHIFT with array_ready low, ignore a start, then clear.
      model_reset(0, 0);
      array_ready = 1'b0;
      low_left    = 1000;
      cfg_row_len = 10'd10;
      cfg_stride  = 8'd2;
      start       = 1'b1;
      tick();
      start = 1'b0;
      repeat (6) tick();
      check("T6_in_shift_busy", 64'(busy), 64'd1);
      check("T6_in_shift_noreq", 64'(mem_req), 64'd0);
      cfg_stride = 8'd0;
      start      = 1'b1;
      tick();
      start = 1'b0;
      check("T6_start_ignored_err", 64'(cfg_err), 64'd0);
      check("T6_start_ignored_done", 64'(done), 64'd0);
      check("T6_start_ignored_busy", 64'(busy), 64'd1);
      clear = 1'b1;
      tick();
      clear = 1'b0;
      check("T6_clear_outputs", 64'(any_out()), 64'd0);
      tick();
      check("T6_clear_stays_idle", 64'(any_out()), 64'd0);
      model_reset(0, 0);

      // T6b: async reset while a strided fetch is outstanding.
      model_reset(3, 0);
      cfg_row_len = 10'd10;
      cfg_stride  = 8'd2;
      start       = 1'b1;
      tick();
      start = 1'b0;
      begin
         bit seen = 1'b0;
         for (int t = 0; t < 20; t++) begin
            tick();
            if (buf_load) begin
               seen = 1'b1;
               break;
            end
         end
         check("T6_load_seen", 64'(seen), 64'd1);
      end
      tick();
      tick();
      check("T6_fetch_s_req", 64'(mem_req), 64'd1);
      reset = 1'b0;
      #1;
      check("T6_reset_outputs", 64'(any_out()), 64'd0);
      tick();
      check("T6_reset_held", 64'(any_out()), 64'd0);
      reset = 1'b1;
      model_reset(0, 0);
      @(negedge clk);

      run_row("T6_rerun", 10, 2, 0, 0, 3);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
